branch_checkpoint_queue: RTL and testbench
==========================================

Name: branch_checkpoint_queue

Overview:
In-order FIFO of in-flight branch prediction metadata. Sits between fetch-side prediction (BTB, direction predictor, RAS) and the execute-side resolution logic. Fetch allocates an entry per predicted branch. Execute resolves the oldest entry and gets back what was predicted, the GHR snapshot and the RAS checkpoint. On a misprediction the queue drains all younger state and drives RAS recovery.

Parameters:
DEPTH, 8, number of entries; power of 2, at least 2
GHR_BITS, 10, width of the global history snapshot
RAS_CKPT_BITS, 9, width of the RAS checkpoint
PTR_BITS, $clog2(DEPTH), tag/index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
alloc_valid  in  1  fetch allocates an entry this cycle
alloc_pc  in  32  branch PC
alloc_pred_taken  in  1  predicted direction
alloc_pred_target  in  32  predicted target
alloc_ghr  in  GHR_BITS  GHR at prediction time
alloc_ras_ckpt  in  RAS_CKPT_BITS  RAS checkpoint at prediction time
alloc_ready  out  1  queue not full
alloc_tag  out  PTR_BITS  tag the next allocation receives (tail index)
head_valid  out  1  queue non-empty
head_tag  out  PTR_BITS  head index
head_pc  out  32  head entry PC
head_pred_taken  out  1  head entry predicted direction
head_pred_target  out  32  head entry predicted target
head_ghr  out  GHR_BITS  head entry GHR snapshot
head_ras_ckpt  out  RAS_CKPT_BITS  head entry RAS checkpoint
resolve_valid  in  1  execute resolves a branch
resolve_tag  in  PTR_BITS  tag of the resolving branch
resolve_mispredict  in  1  resolved branch was mispredicted
flush  in  1  external flush (exception/redirect)
ras_recover  out  1  one-cycle registered RAS recovery pulse
ras_recover_checkpoint  out  RAS_CKPT_BITS  checkpoint accompanying ras_recover
count  out  PTR_BITS+1  number of occupied entries
tag_error  out  1  sticky: illegal resolve seen

Behaviour:
- Reset (rst low, asynchronous):
  - head, tail, count = 0; head_valid = 0; alloc_ready = 1; alloc_tag = 0.
  - ras_recover = 0, ras_recover_checkpoint = 0, tag_error = 0.
  - Storage contents are don't-care; head_* data outputs are driven to 0 while the queue is empty.
- Pointers are PTR_BITS wide and wrap modulo DEPTH. Full and empty are distinguished by count.
- Allocate:
  - Occurs when alloc_valid && alloc_ready. The entry is written at tail, tail increments.
  - alloc_valid while full is ignored: no write, no error.
  - alloc_ready is computed from the current-cycle count only. There is no full-and-pop bypass.
- Head outputs are combinational reads of the head entry. There is no write-through: an allocation into an empty queue becomes visible on head_* the next cycle.
- Legal resolve: resolve_valid && head_valid && resolve_tag == head_tag.
  - Correct (resolve_mispredict = 0): head increments.
  - Mispredict (resolve_mispredict = 1): all entries are discarded (head = tail, count = 0), and any same-cycle allocation is dropped. On the next cycle ras_recover = 1 for exactly one cycle, with ras_recover_checkpoint = the resolved entry's ras_ckpt.
- Illegal resolve: resolve_valid while empty, or with a tag mismatch. No state change; tag_error is set and holds until reset.
- Simultaneous legal correct resolve and allocate: both happen and count is unchanged. When full, the allocation is refused in that cycle.
- flush:
  - Clears the queue (head = tail, count = 0) and drops a same-cycle allocation.
  - Has priority over a same-cycle resolve; ras_recover is not asserted.
  - Does not clear tag_error.
- ras_recover_checkpoint holds its last value between pulses.
- count arithmetic: count_next = count + alloc_accept − pop, clamped by construction to 0..DEPTH.

Test Plan:
- Reset, then alloc pc=0x100 ghr=0x2A ckpt=0x013 → next cycle head_valid=1, head_tag=0, head_pc=0x100, head_ghr=0x2A, count=1.
- Alloc 8 entries with no resolve → alloc_ready=0 and count=8. A 9th alloc is ignored; tail and count are unchanged.
- Full queue, legal correct resolve plus alloc in the same cycle → alloc refused, count=7. Next cycle alloc accepted, count=8, tail wrapped to 1.
- 3 entries (ckpt 0x011, 0x022, 0x033), resolve tag 0 with mispredict plus a same-cycle alloc → next cycle count=0, head_valid=0, ras_recover=1, ras_recover_checkpoint=0x011. The cycle after, ras_recover=0.
- Resolve with tag 2 while head_tag=0 → no pop, count unchanged, tag_error=1 stays set. Resolve on an empty queue → tag_error stays set.
- 2 entries, flush and mispredict resolve in the same cycle → count=0, ras_recover stays 0. Assert rst mid-operation → all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/branch_checkpoint_queue.sv
// In-order FIFO of in-flight branch prediction metadata between fetch-side prediction
// and execute-side resolution, with mispredict drain and RAS recovery pulse.
module branch_checkpoint_queue #(
    parameter int DEPTH         = 8,
    parameter int GHR_BITS      = 10,
    parameter int RAS_CKPT_BITS = 9,
    localparam int PTR_BITS     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic [31:0]              alloc_pc,
    input  logic                     alloc_pred_taken,
    input  logic [31:0]              alloc_pred_target,
    input  logic [GHR_BITS-1:0]      alloc_ghr,
    input  logic [RAS_CKPT_BITS-1:0] alloc_ras_ckpt,
    output logic                     alloc_ready,
    output logic [PTR_BITS-1:0]      alloc_tag,
    output logic                     head_valid,
    output logic [PTR_BITS-1:0]      head_tag,
    output logic [31:0]              head_pc,
    output logic                     head_pred_taken,
    output logic [31:0]              head_pred_target,
    output logic [GHR_BITS-1:0]      head_ghr,
    output logic [RAS_CKPT_BITS-1:0] head_ras_ckpt,
    input  logic                     resolve_valid,
    input  logic [PTR_BITS-1:0]      resolve_tag,
    input  logic                     resolve_mispredict,
    input  logic                     flush,
    output logic                     ras_recover,
    output logic [RAS_CKPT_BITS-1:0] ras_recover_checkpoint,
    output logic [PTR_BITS:0]        count,
    output logic                     tag_error
);

    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
    localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS+1)'(DEPTH);

    logic [31:0]              pc_mem     [DEPTH];
    logic                     taken_mem  [DEPTH];
    logic [31:0]              target_mem [DEPTH];
    logic [GHR_BITS-1:0]      ghr_mem    [DEPTH];
    logic [RAS_CKPT_BITS-1:0] ckpt_mem   [DEPTH];

    logic [PTR_BITS-1:0] head_ptr;
    logic [PTR_BITS-1:0] tail_ptr;
    logic [PTR_BITS-1:0] head_ptr_next;
    logic [PTR_BITS-1:0] tail_ptr_next;
    logic [PTR_BITS:0]   count_next;

    logic resolve_legal;
    logic resolve_illegal;
    logic mispredict_take;
    logic clear_all;
    logic alloc_accept;
    logic pop;

    assign head_valid  = (count != '0);
    assign alloc_ready = (count != CNT_FULL);
    assign alloc_tag   = tail_ptr;
    assign head_tag    = head_ptr;

    assign resolve_legal   = resolve_valid && head_valid && (resolve_tag == head_ptr);
    assign resolve_illegal = resolve_valid && !resolve_legal;
    // A flush overrides the resolve entirely, so no recovery pulse is raised under it.
    assign mispredict_take = resolve_legal && resolve_mispredict && !flush;
    assign clear_all       = flush || mispredict_take;
    assign alloc_accept    = alloc_valid && alloc_ready && !clear_all;
    assign pop             = resolve_legal && !resolve_mispredict && !flush;

    always_comb begin
        head_ptr_next = head_ptr;
        tail_ptr_next = tail_ptr;
        count_next    = count;
        if (clear_all) begin
            head_ptr_next = tail_ptr;
            count_next    = '0;
        end else begin
            if (alloc_accept) tail_ptr_next = tail_ptr + PTR_ONE;
            if (pop)          head_ptr_next = head_ptr + PTR_ONE;
            case ({alloc_accept, pop})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr               <= '0;
            tail_ptr               <= '0;
            count                  <= '0;
            ras_recover            <= 1'b0;
            ras_recover_checkpoint <= '0;
            tag_error              <= 1'b0;
        end else begin
            head_ptr    <= head_ptr_next;
            tail_ptr    <= tail_ptr_next;
            count       <= count_next;
            ras_recover <= mispredict_take;
            if (mispredict_take) ras_recover_checkpoint <= ckpt_mem[head_ptr];
            if (resolve_illegal) tag_error <= 1'b1;
        end
    end

    // Payload storage needs no reset; empty-queue reads are masked below.
    always_ff @(posedge clk) begin
        if (alloc_accept) begin
            pc_mem[tail_ptr]     <= alloc_pc;
            taken_mem[tail_ptr]  <= alloc_pred_taken;
            target_mem[tail_ptr] <= alloc_pred_target;
            ghr_mem[tail_ptr]    <= alloc_ghr;
            ckpt_mem[tail_ptr]   <= alloc_ras_ckpt;
        end
    end

    always_comb begin
        head_pc          = '0;
        head_pred_taken  = 1'b0;
        head_pred_target = '0;
        head_ghr         = '0;
        head_ras_ckpt    = '0;
        if (head_valid) begin
            head_pc          = pc_mem[head_ptr];
            head_pred_taken  = taken_mem[head_ptr];
            head_pred_target = target_mem[head_ptr];
            head_ghr         = ghr_mem[head_ptr];
            head_ras_ckpt    = ckpt_mem[head_ptr];
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_queue.sv
// Directed self-checking bench for branch_checkpoint_queue: each scenario task
// drives its own vectors and compares against hand-computed values.
module tb_branch_checkpoint_queue;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_pred_taken;
    logic [31:0] alloc_pred_target;
    logic [9:0]  alloc_ghr;
    logic [8:0]  alloc_ras_ckpt;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        head_valid;
    logic [2:0]  head_tag;
    logic [31:0] head_pc;
    logic        head_pred_taken;
    logic [31:0] head_pred_target;
    logic [9:0]  head_ghr;
    logic [8:0]  head_ras_ckpt;
    logic        resolve_valid;
    logic [2:0]  resolve_tag;
    logic        resolve_mispredict;
    logic        flush;
    logic        ras_recover;
    logic [8:0]  ras_recover_checkpoint;
    logic [3:0]  count;
    logic        tag_error;

    int checks = 0;
    int errors = 0;

    branch_checkpoint_queue dut (
        .clk                    (clk),
        .rst                    (rst),
        .alloc_valid            (alloc_valid),
        .alloc_pc               (alloc_pc),
        .alloc_pred_taken       (alloc_pred_taken),
        .alloc_pred_target      (alloc_pred_target),
        .alloc_ghr              (alloc_ghr),
        .alloc_ras_ckpt         (alloc_ras_ckpt),
        .alloc_ready            (alloc_ready),
        .alloc_tag              (alloc_tag),
        .head_valid             (head_valid),
        .head_tag               (head_tag),
        .head_pc                (head_pc),
        .head_pred_taken        (head_pred_taken),
        .head_pred_target       (head_pred_target),
        .head_ghr               (head_ghr),
        .head_ras_ckpt          (head_ras_ckpt),
        .resolve_valid          (resolve_valid),
        .resolve_tag            (resolve_tag),
        .resolve_mispredict     (resolve_mispredict),
        .flush                  (flush),
        .ras_recover            (ras_recover),
        .ras_recover_checkpoint (ras_recover_checkpoint),
        .count                  (count),
        .tag_error              (tag_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alloc_valid        = 1'b0;
        alloc_pc           = '0;
        alloc_pred_taken   = 1'b0;
        alloc_pred_target  = '0;
        alloc_ghr          = '0;
        alloc_ras_ckpt     = '0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_mispredict = 1'b0;
        flush              = 1'b0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [9:0] ghr, input logic [8:0] ckpt);
        alloc_valid       = 1'b1;
        alloc_pc          = pc;
        alloc_pred_taken  = pc[2];
        alloc_pred_target = pc + 32'h40;
        alloc_ghr         = ghr;
        alloc_ras_ckpt    = ckpt;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [9:0] ghr, input logic [8:0] ckpt);
        set_alloc(pc, ghr, ckpt);
        tick();
        idle_inputs();
    endtask

    task automatic do_resolve(input logic [2:0] tag, input logic mis);
        resolve_valid      = 1'b1;
        resolve_tag        = tag;
        resolve_mispredict = mis;
        tick();
        idle_inputs();
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b0;
        #2;
        checks++;
        if (count !== 4'd0 || head_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: count=%0d head_valid=%b alloc_ready=%b alloc_tag=%0d, want 0 0 1 0",
                     count, head_valid, alloc_ready, alloc_tag);
        end
        checks++;
        if (ras_recover !== 1'b0 || ras_recover_checkpoint !== 9'd0 || tag_error !== 1'b0 || head_pc !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_misc: ras_recover=%b ckpt=%h tag_error=%b head_pc=%h, want 0 000 0 00000000",
                     ras_recover, ras_recover_checkpoint, tag_error, head_pc);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_first_alloc;
        do_reset();
        set_alloc(32'h100, 10'h2A, 9'h013);
        #1;
        checks++;
        if (head_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_write_through: head_valid=%b, want 0", head_valid);
        end
        tick();
        idle_inputs();
        checks++;
        if (head_valid !== 1'b1 || head_tag !== 3'd0 || count !== 4'd1 || alloc_tag !== 3'd1) begin
            errors++;
            $display("[TB] FAIL first_alloc_ctrl: head_valid=%b head_tag=%0d count=%0d alloc_tag=%0d, want 1 0 1 1",
                     head_valid, head_tag, count, alloc_tag);
        end
        checks++;
        if (head_pc !== 32'h100 || head_ghr !== 10'h2A || head_ras_ckpt !== 9'h013 ||
            head_pred_taken !== 1'b0 || head_pred_target !== 32'h140) begin
            errors++;
            $display("[TB] FAIL first_alloc_data: pc=%h ghr=%h ckpt=%h taken=%b target=%h, want 00000100 02a 013 0 00000140",
                     head_pc, head_ghr, head_ras_ckpt, head_pred_taken, head_pred_target);
        end
    endtask

    task automatic test_fill;
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(32'h1000 + 32'(i * 4), 10'(i), 9'(i));
        checks++;
        if (alloc_ready !== 1'b0 || count !== 4'd8 || alloc_tag !== 3'd0) begin
            errors++;
            $display("[TB] FAIL full: alloc_ready=%b count=%0d alloc_tag=%0d, want 0 8 0", alloc_ready, count, alloc_tag);
        end
        do_alloc(32'h9999, 10'h3FF, 9'h1FF);
        checks++;
        if (count !== 4'd8 || alloc_tag !== 3'd0 || head_pc !== 32'h1000 || tag_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ninth_alloc: count=%0d alloc_tag=%0d head_pc=%h tag_error=%b, want 8 0 00001000 0",
                     count, alloc_tag, head_pc, tag_error);
        end
    endtask

    task automatic test_full_resolve_alloc;
        resolve_valid = 1'b1;
        resolve_tag   = 3'd0;
        set_alloc(32'h2000, 10'h155, 9'h0AA);
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd7 || head_tag !== 3'd1 || head_pc !== 32'h1004 || alloc_tag !== 3'd0) begin
            errors++;
            $display("[TB] FAIL full_pop_refuse: count=%0d head_tag=%0d head_pc=%h alloc_tag=%0d, want 7 1 00001004 0",
                     count, head_tag, head_pc, alloc_tag);
        end
        do_alloc(32'h2000, 10'h155, 9'h0AA);
        checks++;
        if (count !== 4'd8 || alloc_tag !== 3'd1 || alloc_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_alloc: count=%0d alloc_tag=%0d alloc_ready=%b, want 8 1 0", count, alloc_tag, alloc_ready);
        end
        for (int i = 1; i < 8; i++) do_resolve(3'(i), 1'b0);
        checks++;
        if (count !== 4'd1 || head_tag !== 3'd0 || head_pc !== 32'h2000 || head_ghr !== 10'h155 || head_ras_ckpt !== 9'h0AA) begin
            errors++;
            $display("[TB] FAIL wrap_head: count=%0d tag=%0d pc=%h ghr=%h ckpt=%h, want 1 0 00002000 155 0aa",
                     count, head_tag, head_pc, head_ghr, head_ras_ckpt);
        end
    endtask

    task automatic test_mispredict;
        do_reset();
        do_alloc(32'h400, 10'h001, 9'h011);
        do_alloc(32'h404, 10'h002, 9'h022);
        do_alloc(32'h408, 10'h003, 9'h033);
        resolve_valid      = 1'b1;
        resolve_tag        = 3'd0;
        resolve_mispredict = 1'b1;
        set_alloc(32'h500, 10'h004, 9'h044);
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd0 || head_valid !== 1'b0 || ras_recover !== 1'b1 || ras_recover_checkpoint !== 9'h011) begin
            errors++;
            $display("[TB] FAIL mispredict: count=%0d head_valid=%b ras_recover=%b ckpt=%h, want 0 0 1 011",
                     count, head_valid, ras_recover, ras_recover_checkpoint);
        end
        checks++;
        if (alloc_tag !== 3'd3 || head_tag !== 3'd3 || head_pc !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mispredict_ptrs: alloc_tag=%0d head_tag=%0d head_pc=%h, want 3 3 00000000",
                     alloc_tag, head_tag, head_pc);
        end
        tick();
        checks++;
        if (ras_recover !== 1'b0 || ras_recover_checkpoint !== 9'h011) begin
            errors++;
            $display("[TB] FAIL recover_pulse: ras_recover=%b ckpt=%h, want 0 011", ras_recover, ras_recover_checkpoint);
        end
    endtask

    task automatic test_tag_error;
        do_reset();
        do_alloc(32'h600, 10'h0, 9'h001);
        do_alloc(32'h604, 10'h0, 9'h002);
        do_alloc(32'h608, 10'h0, 9'h003);
        do_resolve(3'd2, 1'b0);
        checks++;
        if (count !== 4'd3 || head_tag !== 3'd0 || tag_error !== 1'b1 || ras_recover !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tag_mismatch: count=%0d head_tag=%0d tag_error=%b ras_recover=%b, want 3 0 1 0",
                     count, head_tag, tag_error, ras_recover);
        end
        flush = 1'b1;
        tick();
        idle_inputs();
        do_resolve(3'd3, 1'b1);
        checks++;
        if (count !== 4'd0 || tag_error !== 1'b1 || ras_recover !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_resolve: count=%0d tag_error=%b ras_recover=%b, want 0 1 0", count, tag_error, ras_recover);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        do_alloc(32'h300, 10'h010, 9'h005);
        resolve_valid = 1'b1;
        resolve_tag   = 3'd0;
        set_alloc(32'h30C, 10'h020, 9'h006);
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd1 || head_tag !== 3'd1 || head_pc !== 32'h30C || head_pred_taken !== 1'b1 || tag_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pop_and_alloc: count=%0d head_tag=%0d pc=%h taken=%b tag_error=%b, want 1 1 0000030c 1 0",
                     count, head_tag, head_pc, head_pred_taken, tag_error);
        end
    endtask

    task automatic test_flush_priority;
        do_reset();
        do_alloc(32'h700, 10'h0, 9'h077);
        do_alloc(32'h704, 10'h0, 9'h088);
        flush              = 1'b1;
        resolve_valid      = 1'b1;
        resolve_tag        = 3'd0;
        resolve_mispredict = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd0 || head_valid !== 1'b0 || ras_recover !== 1'b0 || ras_recover_checkpoint !== 9'd0) begin
            errors++;
            $display("[TB] FAIL flush_priority: count=%0d head_valid=%b ras_recover=%b ckpt=%h, want 0 0 0 000",
                     count, head_valid, ras_recover, ras_recover_checkpoint);
        end
        tick();
        checks++;
        if (ras_recover !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_no_pulse: ras_recover=%b, want 0", ras_recover);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        do_alloc(32'h800, 10'h0, 9'h0F0);
        do_alloc(32'h804, 10'h0, 9'h0F1);
        do_resolve(3'd0, 1'b1);
        do_resolve(3'd5, 1'b0);
        rst = 1'b0;
        #2;
        checks++;
        if (count !== 4'd0 || head_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0 || head_tag !== 3'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_ctrl: count=%0d head_valid=%b alloc_ready=%b alloc_tag=%0d head_tag=%0d, want 0 0 1 0 0",
                     count, head_valid, alloc_ready, alloc_tag, head_tag);
        end
        checks++;
        if (tag_error !== 1'b0 || ras_recover !== 1'b0 || ras_recover_checkpoint !== 9'd0 || head_pc !== 32'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_misc: tag_error=%b ras_recover=%b ckpt=%h head_pc=%h, want 0 0 000 00000000",
                     tag_error, ras_recover, ras_recover_checkpoint, head_pc);
        end
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_first_alloc();
        test_fill();
        test_full_resolve_alloc();
        test_mispredict();
        test_tag_error();
        test_back_to_back();
        test_flush_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
